// File: rtl/mnist_layer_scheduler.sv
// Top-level sequencer for the MNIST datapath: launches the layer controllers
// one at a time, waits for each done pulse, counts images and run cycles,
// and flags a layer that never answers.
//
// Ports:
//   clk_i          clock, rising edge
//   rstn_i         asynchronous active-low reset
//   start_i        begins a run (only from IDLE or ERR)
//   img_valid_i    next input image is resident
//   layer_done_i   per-layer done pulses
//   layer_start_o  one-hot single-cycle launch pulse
//   active_layer_o layer currently launched or awaited
//   img_cnt_o      images completed in this run
//   cnt_o          saturating run-cycle counter (global cnt for layers)
//   busy_o         high outside IDLE and ERR
//   done_o         one-cycle pulse at run completion
//   err_o          sticky layer timeout flag
module mnist_layer_scheduler #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned NUM_IMAGES = 10,
  parameter int unsigned TIMEOUT    = 8191,
  localparam int unsigned ACT_W     = 3,
  localparam int unsigned IMG_W     = 8,
  localparam int unsigned CNT_W     = 13
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  img_valid_i,
  input  logic [NUM_LAYERS-1:0] layer_done_i,
  output logic [NUM_LAYERS-1:0] layer_start_o,
  output logic [ACT_W-1:0]      active_layer_o,
  output logic [IMG_W-1:0]      img_cnt_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Watchdog only needs to hold 0..TIMEOUT-1 before the expiry decision.
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IMG,
    S_LAUNCH,
    S_WAIT_DONE,
    S_NEXT_IMG,
    S_FINISH,
    S_ERR
  } state_t;

  state_t                state;
  logic [WD_W-1:0]       wd;
  logic [NUM_LAYERS-1:0] active_sel;
  logic                  done_hit;
  logic [ACT_W-1:0]      act_next;
  logic [IMG_W-1:0]      img_next;

  // Only the awaited layer's done bit is relevant; stray bits are masked off.
  assign active_sel = NUM_LAYERS'(1) << active_layer_o;
  assign done_hit   = |(layer_done_i & active_sel);
  assign act_next   = active_layer_o + ACT_W'(1);
  assign img_next   = img_cnt_o + IMG_W'(1);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= S_IDLE;
      wd             <= '0;
      layer_start_o  <= '0;
      active_layer_o <= '0;
      img_cnt_o      <= '0;
      cnt_o          <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      layer_start_o <= '0;
      done_o        <= 1'b0;

      if (busy_o && (cnt_o != CNT_MAX)) begin
        cnt_o <= cnt_o + CNT_W'(1);
      end

      case (state)
        S_IDLE, S_ERR: begin
          if (start_i) begin
            state          <= S_WAIT_IMG;
            busy_o         <= 1'b1;
            img_cnt_o      <= '0;
            active_layer_o <= '0;
            cnt_o          <= '0;
            wd             <= '0;
            err_o          <= 1'b0;
          end
        end

        S_WAIT_IMG: begin
          if (img_valid_i) begin
            state          <= S_LAUNCH;
            active_layer_o <= '0;
            layer_start_o  <= NUM_LAYERS'(1);
          end
        end

        S_LAUNCH: begin
          state <= S_WAIT_DONE;
          wd    <= '0;
        end

        // Done is tested before the watchdog so a late answer still wins.
        S_WAIT_DONE: begin
          if (done_hit) begin
            if (active_layer_o == ACT_W'(NUM_LAYERS - 1)) begin
              state <= S_NEXT_IMG;
            end else begin
              state          <= S_LAUNCH;
              active_layer_o <= act_next;
              layer_start_o  <= NUM_LAYERS'(1) << act_next;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            state  <= S_ERR;
            busy_o <= 1'b0;
            err_o  <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end

        S_NEXT_IMG: begin
          img_cnt_o <= img_next;
          if (img_next == IMG_W'(NUM_IMAGES)) begin
            state  <= S_FINISH;
            done_o <= 1'b1;
          end else begin
            state          <= S_WAIT_IMG;
            active_layer_o <= '0;
          end
        end

        S_FINISH: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_layer_scheduler.sv
// Self-checking bench for mnist_layer_scheduler: a behavioural model of the
// run sequence is compared against every DUT output on each falling edge,
// with directed scenarios plus randomized runs and hand-computed literals.
module tb_mnist_layer_scheduler;

  localparam int NL      = 4;
  localparam int NI      = 2;
  localparam int TO      = 16;
  localparam int CNT_MAX = 8191;

  localparam int P_IDLE      = 0;
  localparam int P_WAIT_IMG  = 1;
  localparam int P_LAUNCH    = 2;
  localparam int P_WAIT_DONE = 3;
  localparam int P_NEXT_IMG  = 4;
  localparam int P_FINISH    = 5;
  localparam int P_ERR       = 6;

  logic          clk          = 1'b0;
  logic          rstn_i       = 1'b0;
  logic          start_i      = 1'b0;
  logic          img_valid_i  = 1'b0;
  logic [NL-1:0] layer_done_i = '0;
  logic [NL-1:0] layer_start_o;
  logic [2:0]    active_layer_o;
  logic [7:0]    img_cnt_o;
  logic [12:0]   cnt_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  mnist_layer_scheduler #(
    .NUM_LAYERS(NL),
    .NUM_IMAGES(NI),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .start_i       (start_i),
    .img_valid_i   (img_valid_i),
    .layer_done_i  (layer_done_i),
    .layer_start_o (layer_start_o),
    .active_layer_o(active_layer_o),
    .img_cnt_o     (img_cnt_o),
    .cnt_o         (cnt_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run phase, awaited layer, images done, cycles, errors.
  int m_phase  = P_IDLE;
  int m_active = 0;
  int m_img    = 0;
  int m_cnt    = 0;
  int m_wait   = 0;
  int m_err    = 0;

  function automatic int m_busy();
    return (m_phase != P_IDLE && m_phase != P_ERR) ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rstn_i);
      if (!rstn_i) begin
        m_phase = P_IDLE; m_active = 0; m_img = 0;
        m_cnt = 0; m_wait = 0; m_err = 0;
      end else begin
        if (m_busy() == 1 && m_cnt < CNT_MAX) m_cnt++;
        case (m_phase)
          P_IDLE, P_ERR:
            if (start_i) begin
              m_phase = P_WAIT_IMG; m_img = 0; m_active = 0; m_cnt = 0; m_err = 0;
            end
          P_WAIT_IMG:
            if (img_valid_i) begin
              m_phase = P_LAUNCH; m_active = 0;
            end
          P_LAUNCH: begin
            m_phase = P_WAIT_DONE; m_wait = 0;
          end
          P_WAIT_DONE: begin
            m_wait++;
            if (layer_done_i[m_active]) begin
              if (m_active == NL - 1) m_phase = P_NEXT_IMG;
              else begin m_active++; m_phase = P_LAUNCH; end
            end else if (m_wait == TO) begin
              m_phase = P_ERR; m_err = 1;
            end
          end
          P_NEXT_IMG: begin
            m_img++;
            if (m_img == NI) m_phase = P_FINISH;
            else begin m_phase = P_WAIT_IMG; m_active = 0; end
          end
          P_FINISH: m_phase = P_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison plus a small monitor of launches and done pulses.
  int done_seen = 0;
  int seq[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("layer_start", int'(layer_start_o), (m_phase == P_LAUNCH) ? (1 << m_active) : 0);
      chk("active_layer", int'(active_layer_o), m_active);
      chk("img_cnt", int'(img_cnt_o), m_img);
      chk("cnt", int'(cnt_o), m_cnt);
      chk("busy", int'(busy_o), m_busy());
      chk("done", int'(done_o), (m_phase == P_FINISH) ? 1 : 0);
      chk("err", int'(err_o), m_err);
      if (done_o) done_seen++;
      if (layer_start_o != '0) seq.push_back(int'(layer_start_o));
    end
  end

  // Layer responders and image-valid driver, acting just after the falling edge.
  int   resp_delay = 5;
  int   mute       = -1;
  int   img_mode   = 0;
  bit   noise_en   = 1'b0;
  int   cd         = 0;
  int   cur        = 0;
  logic [NL-1:0] rd;
  logic [NL-1:0] nz;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      rd = '0;
      if (!rstn_i) begin
        cd = 0;
      end else if (layer_start_o != '0) begin
        for (int i = 0; i < NL; i++) if (layer_start_o[i]) cur = i;
        cd = (cur == mute) ? 0 : resp_delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) rd[cur] = 1'b1;
      end
      if (noise_en && rstn_i) begin
        if (m_phase == P_LAUNCH) begin
          rd[m_active] = 1'b1;
        end else if (m_phase == P_WAIT_DONE) begin
          nz = NL'($urandom);
          nz[m_active] = 1'b0;
          if (m_active == 0) nz[2] = 1'b1;
          rd = rd | nz;
        end
      end
      layer_done_i = rd;
      case (img_mode)
        0:       img_valid_i = 1'b0;
        1:       img_valid_i = 1'b1;
        default: img_valid_i = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd, input string tag);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      start_i = 1'b0;
      n++;
      if (rnd && busy_o && $urandom_range(0, 39) == 0) start_i = 1'b1;
    end
    start_i = 1'b0;
    chk(tag, int'(busy_o), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not end, got running expected finished");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  int  n;
  bit  idle_busy;

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_cnt", int'(cnt_o), 0);
    chk("rst_layer_start", int'(layer_start_o), 0);
    rstn_i = 1'b1;

    // Idle with no start.
    idle_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy_o) idle_busy = 1'b1;
    end
    chk("idle_busy_100", int'(idle_busy), 0);

    // Nominal run: each layer answers 5 cycles after its start.
    img_mode = 1; resp_delay = 5; noise_en = 1'b0; mute = -1;
    seq.delete(); done_seen = 0;
    pulse_start();
    wait_idle(500, 1'b0, "nominal_end");
    chk("nom_seq_len", seq.size(), 8);
    for (int i = 0; i < 8; i++) chk("nom_seq", (i < seq.size()) ? seq[i] : 0, 1 << (i % 4));
    chk("nom_done_cnt", done_seen, 1);
    chk("nom_img_cnt", int'(img_cnt_o), 2);
    chk("nom_cnt", int'(cnt_o), 53);
    repeat (10) @(negedge clk);
    chk("nom_cnt_frozen", int'(cnt_o), 53);

    // Stray/early done bits, then image valid held low after image 1.
    img_mode = 1; resp_delay = 3; noise_en = 1'b1;
    pulse_start();
    n = 0;
    while (img_cnt_o != 8'd1 && n < 200) begin @(negedge clk); n++; end
    img_mode = 0;
    chk("stray_img1", int'(img_cnt_o), 1);
    chk("stray_cnt_img1", int'(cnt_o), 18);
    repeat (20) @(negedge clk);
    chk("hold_busy", int'(busy_o), 1);
    chk("hold_cnt", int'(cnt_o), 38);
    chk("hold_no_launch", int'(layer_start_o), 0);
    img_mode = 1;
    wait_idle(500, 1'b0, "stray_end");
    noise_en = 1'b0;
    chk("stray_img_cnt", int'(img_cnt_o), 2);

    // Timeout with layer 1 silent, then restart from ERR.
    mute = 1; resp_delay = 4; img_mode = 1;
    pulse_start();
    n = 0;
    while (!err_o && n < 200) begin @(negedge clk); n++; end
    chk("to_err", int'(err_o), 1);
    chk("to_busy", int'(busy_o), 0);
    chk("to_active", int'(active_layer_o), 1);
    chk("to_cnt", int'(cnt_o), 23);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", int'(err_o), 1);
    mute = -1; seq.delete();
    pulse_start();
    chk("to_err_cleared", int'(err_o), 0);
    wait_idle(500, 1'b0, "rerun_end");
    chk("rerun_first_launch", (seq.size() > 0) ? seq[0] : 0, 1);
    chk("rerun_img_cnt", int'(img_cnt_o), 2);

    // Cycle counter saturation with an ignored mid-run start.
    img_mode = 0;
    pulse_start();
    repeat (4000) @(negedge clk);
    pulse_start();
    repeat (4300) @(negedge clk);
    chk("sat_cnt", int'(cnt_o), 8191);
    chk("sat_busy", int'(busy_o), 1);
    chk("sat_img_cnt", int'(img_cnt_o), 0);
    img_mode = 1;
    wait_idle(500, 1'b0, "sat_end");
    chk("sat_cnt_final", int'(cnt_o), 8191);
    chk("sat_img_final", int'(img_cnt_o), 2);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      resp_delay = $urandom_range(1, 6);
      noise_en   = ($urandom_range(0, 1) == 1);
      img_mode   = 2;
      done_seen  = 0;
      pulse_start();
      wait_idle(3000, 1'b1, "rand_end");
      chk("rand_img_cnt", int'(img_cnt_o), NI);
      chk("rand_done_cnt", done_seen, 1);
    end
    noise_en = 1'b0;

    // Reset asserted in the middle of a LAUNCH cycle.
    img_mode = 1; resp_delay = 5;
    pulse_start();
    n = 0;
    while (layer_start_o == '0 && n < 50) begin @(negedge clk); n++; end
    chk("rl_launch_seen", (layer_start_o != '0) ? 1 : 0, 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("rl_layer_start", int'(layer_start_o), 0);
    chk("rl_active", int'(active_layer_o), 0);
    chk("rl_img_cnt", int'(img_cnt_o), 0);
    chk("rl_cnt", int'(cnt_o), 0);
    chk("rl_busy", int'(busy_o), 0);
    chk("rl_done", int'(done_o), 0);
    chk("rl_err", int'(err_o), 0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", int'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
